// File: rtl/dh_decrypt_pkg.sv
// Shared constants and FSM encoding for the DH/ElGamal decryption block.
package dh_decrypt_pkg;

   localparam int W_DEF = 32;

   function automatic int lat_of(input int w);
      return 4*w*w + w + 2;
   endfunction

   localparam int LAT = lat_of(W_DEF);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXPK,
      S_EXPI,
      S_MUL,
      S_FIN
   } state_t;

endpackage

// File: rtl/dh_decrypt_mod_mul.sv
// Interleaved shift-add modular multiplier, one bit of a per cycle, MSB first.
module mod_mul
   import dh_decrypt_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] p,
   output logic [W-1:0] r,
   output logic         done
);
   localparam int CW = $clog2(W+1);

   logic [W+1:0]  r_acc;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_p;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic          r_done;

   // With acc < p and b < p, 2*acc + b < 3p, so two conditional subtracts suffice.
   function automatic logic [W+1:0] step(input logic [W+1:0] acc, input logic bit_i,
                                         input logic [W-1:0] bv, input logic [W-1:0] pv);
      logic [W+1:0] t;
      logic [W+1:0] pp;
      pp = {2'b00, pv};
      t  = (acc << 1) + (bit_i ? {2'b00, bv} : '0);
      if (t >= pp) t = t - pp;
      if (t >= pp) t = t - pp;
      return t;
   endfunction

   // The start cycle already consumes bit W-1, so the result lands exactly W cycles later.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_acc  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_p    <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_acc  <= step('0, a[W-1], b, p);
            r_a    <= a << 1;
            r_b    <= b;
            r_p    <= p;
            r_cnt  <= CW'(W-1);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_acc <= step(r_acc, r_a[W-1], r_b, r_p);
            r_a   <= r_a << 1;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign r    = r_acc[W-1:0];
   assign done = r_done;

endmodule

// File: rtl/dh_decrypt.sv
// ElGamal receive path: K = C1^X mod P, Kinv = K^(P-2) mod P, M = C2*Kinv mod P.
// One modular multiplier is time-shared by both exponentiations and the final product.
module dh_decrypt
   import dh_decrypt_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         ST,
   input  logic [W-1:0] P,
   input  logic [W-1:0] X,
   input  logic [W-1:0] C1,
   input  logic [W-1:0] C2,
   output logic [W-1:0] K,
   output logic [W-1:0] M,
   output logic         BUSY,
   output logic         DONE,
   output logic         ERR
);
   localparam int BW = $clog2(W);

   state_t        r_state, w_nx;
   logic [W-1:0]  r_p, r_c2, r_base, r_exp, r_acc, r_k, r_m;
   logic [BW-1:0] r_bit;
   logic          r_phase, r_kick, r_err;
   logic [W-1:0]  w_acc_nx, w_a, w_b, w_mres;
   logic          w_start, w_mdone, w_last, w_step, w_bad;

   assign w_bad = (P < W'(3)) || !P[0] || (C1 == '0) || (C1 >= P) || (C2 >= P);

   mod_mul #(.W(W)) u_mul (
      .CLK   (CLK),
      .RST   (RST),
      .start (w_start),
      .a     (w_a),
      .b     (w_b),
      .p     (r_p),
      .r     (w_mres),
      .done  (w_mdone)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_nx;
   end

   // Next multiply is launched in the same cycle the previous one completes, so no gaps.
   always_comb begin
      w_acc_nx = r_acc;
      if (w_mdone && (!r_phase || r_exp[r_bit])) w_acc_nx = w_mres;
      w_last  = w_mdone && r_phase && (r_bit == '0);
      w_step  = w_mdone && !w_last && ((r_state == S_EXPK) || (r_state == S_EXPI));
      w_a     = w_acc_nx;
      w_b     = (w_mdone ? !r_phase : r_phase) ? r_base : w_acc_nx;
      w_start = 1'b0;
      w_nx    = r_state;
      BUSY    = (r_state == S_EXPK) || (r_state == S_EXPI) || (r_state == S_MUL);
      DONE    = (r_state == S_FIN);
      unique case (r_state)
         S_IDLE: if (ST) w_nx = w_bad ? S_FIN : S_EXPK;
         S_EXPK: begin
            w_start = r_kick || (w_mdone && !w_last);
            if (w_last) begin
               if (w_acc_nx == '0) begin
                  w_nx = S_FIN;
               end else begin
                  w_nx    = S_EXPI;
                  w_start = 1'b1;
                  w_a     = W'(1);
                  w_b     = W'(1);
               end
            end
         end
         S_EXPI: begin
            w_start = w_mdone;
            if (w_last) begin
               w_nx = S_MUL;
               w_a  = r_c2;
               w_b  = w_acc_nx;
            end
         end
         S_MUL:   if (w_mdone) w_nx = S_FIN;
         S_FIN:   w_nx = S_IDLE;
         default: w_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_p     <= '0;
         r_c2    <= '0;
         r_base  <= '0;
         r_exp   <= '0;
         r_acc   <= '0;
         r_k     <= '0;
         r_m     <= '0;
         r_bit   <= '0;
         r_phase <= 1'b0;
         r_kick  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_kick <= 1'b0;
         if ((r_state == S_IDLE) && ST) begin
            r_p     <= P;
            r_c2    <= C2;
            r_base  <= C1;
            r_exp   <= X;
            r_acc   <= W'(1);
            r_bit   <= BW'(W-1);
            r_phase <= 1'b0;
            r_k     <= '0;
            r_m     <= '0;
            r_err   <= w_bad;
            r_kick  <= !w_bad;
         end
         if (w_step) begin
            r_acc   <= w_acc_nx;
            r_phase <= !r_phase;
            if (r_phase) r_bit <= r_bit - BW'(1);
         end
         // K becomes the base of the Fermat inversion; exponent switches to P-2.
         if ((r_state == S_EXPK) && w_last) begin
            r_k     <= w_acc_nx;
            r_base  <= w_acc_nx;
            r_acc   <= W'(1);
            r_exp   <= r_p - W'(2);
            r_bit   <= BW'(W-1);
            r_phase <= 1'b0;
            if (w_acc_nx == '0) r_err <= 1'b1;
         end
         if ((r_state == S_MUL) && w_mdone) r_m <= w_mres;
      end
   end

   assign K   = r_k;
   assign M   = r_m;
   assign ERR = r_err;

endmodule

// File: doc/dh_decrypt.md
Name: dh_decrypt

Overview:
- Receive-side counterpart of the Diffie-Hellman/ElGamal encryption path.
- Takes a ciphertext pair (C1, C2), the private exponent X and the prime P.
- Recovers the shared key K = C1^X mod P, its inverse K^-1 = K^(P-2) mod P (Fermat), and the plaintext M = C2 * K^-1 mod P.
- Sits beside the encryption/check blocks in the key-exchange top and uses the same start/done handshake as the exponentiation units.

Parameters:
- W, 32, operand width of P, X, C1, C2, K and M.

Ports:
- CLK   input   1   clock; all logic is rising-edge.
- RST   input   1   asynchronous, active-high reset.
- ST    input   1   start pulse; sampled only in IDLE.
- P     input   W   prime modulus; must be odd and >= 3.
- X     input   W   private exponent.
- C1    input   W   ciphertext part 1 (ephemeral public value).
- C2    input   W   ciphertext part 2 (masked message).
- K     output  W   recovered shared key C1^X mod P.
- M     output  W   recovered plaintext.
- BUSY  output  1   high from the cycle after ST is accepted until DONE.
- DONE  output  1   one-cycle pulse; K, M and ERR are valid from this cycle.
- ERR   output  1   invalid operands or non-invertible key; held until the next accepted ST.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. K, M, BUSY, DONE, ERR and all internal registers are cleared to 0. An operation in flight is abandoned with no DONE pulse.
- Cycle 0 = the cycle ST is sampled high in IDLE. P, X, C1 and C2 are latched in that cycle; later input changes are ignored. ST while BUSY is ignored.
- Operand check on the latched values. If any of P < 3, P even, C1 = 0, C1 >= P or C2 >= P:
  - go to FIN;
  - DONE at cycle 1 with ERR=1, K=0, M=0.
- FSM states: IDLE -> EXPK -> EXPI -> MUL -> FIN -> IDLE.
- EXPK:
  - Computes acc = C1^X mod P by left-to-right square-and-multiply over all W bits of X, MSB first; acc starts at 1.
  - Per bit: one square (acc*acc), then one multiply (acc*C1) that is always performed. Its result is kept only if the X bit is 1, so latency is fixed.
  - The result is registered as K.
- EXPI: same procedure with base K and exponent P-2 (W bits, MSB first), giving Kinv.
  - K = 0 cannot occur for valid operands and prime P.
  - If K = 0 anyway (non-prime P), go straight to FIN with ERR=1, M=0 and K as computed.
- MUL: one modular multiply M = C2*Kinv mod P.
- FIN: DONE=1 for one cycle, BUSY drops in the same cycle, then the FSM returns to IDLE. K and M hold until the next accepted ST, which clears ERR.
- Modular multiply (sub-module): interleaved shift-add.
  - Start r = 0. For i = W-1 down to 0: r = 2r; if a[i], r = r + b; then subtract P up to twice so that r < P.
  - Internal width W+2 bits; operands must be < P.
  - Exactly W cycles per multiply, one bit per cycle.
- Latency, valid path: DONE at cycle 4*W*W + W + 2 (cycle 4130 for W=32). The error path is fixed at cycle 1.
- X = 0 gives K = 1 and M = C2.
- C2 = 0 gives M = 0 with ERR=0.

Decomposition:
- Shared package holds:
  - W default (32);
  - state encoding for IDLE, EXPK, EXPI, MUL, FIN;
  - constant LAT = 4*W*W + W + 2, which the bench also uses.
- One sub-module, mod_mul (ports CLK, RST, start, a, b, p, r, done), instantiated once and time-shared by EXPK, EXPI and MUL.
- The exponent bit counter and the square/multiply phase flag live in dh_decrypt.

Test Plan:
- P=23, X=6, C1=10, C2=9, ST pulse -> DONE at cycle 4130, K=6, M=13, ERR=0. BUSY is high on cycles 1..4129 and low in the DONE cycle.
- P=0xFFFFFFFB, X=1, C1=2, C2=5 -> K=2, M=0x80000000, ERR=0.
- P=23, X=0, C1=7, C2=11 -> K=1, M=11. Also C2=0 -> M=0, ERR=0.
- P=23, C1=0 (repeat with C1=23, with P=22, and with P=1) -> DONE at cycle 1, ERR=1, K=0, M=0. The next valid ST clears ERR.
- Second ST during BUSY (cycle 100) -> ignored. Single DONE at cycle 4130, result unchanged.
- RST asserted asynchronously mid-EXPI (cycle 2500) -> all outputs 0 immediately and no DONE. A fresh ST after release gives the correct result at LAT.
